fpu_issue: RTL
==============

# fpu_issue

Sequencer between the CPU execute stage and `fpu_controller`. It accepts one FP request per transaction on a valid/ready port and runs the stb/ack handshake for ops 0000–0011 against the controller. It holds `fpu_op` stable for the whole transaction, collects the result, and returns it on a valid/ready response port. Compares (feq/flt/fle) are resolved locally, since the controller does not implement them; all other op codes complete as illegal.

## Interface
Parameters:
- `CYCLE_CNT_W`, 16: width of the per-transaction busy-cycle counter `rsp_cycles`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low. Shared with `fpu_controller`.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request. High only in IDLE.
- `req_op` in 4: op code (0000 fadd … 1000 fle).
- `req_a`, `req_b` in 32 each: operands (IEEE-754 single).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_data` out 32: result.
- `rsp_illegal` out 1: op not supported.
- `rsp_cycles` out CYCLE_CNT_W: cycles from acceptance to first `rsp_valid` cycle. Saturates at all-ones.
- `fpu_op` out 4: op to the controller.
- `fpu_in1`, `fpu_in2` out 32 each: operands to the controller. `fpu_in2` is passed unmodified; the controller flips the sign for fsub.
- `fpu_in1_stb`, `fpu_in2_stb` out 1 each: operand strobes. Always equal.
- `fpu_in1_ack`, `fpu_in2_ack` in 1 each: operand acks.
- `fpu_out` in 32: controller result.
- `fpu_out_stb` in 1: controller result valid.
- `fpu_out_ack` out 1: result taken.

## Operation
States:
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op/a/b and clear the cycle counter.
  - op ≤ 0011 → SEND; otherwise → LOCAL.
- SEND:
  - Strobes high.
  - Sticky flags `got1`/`got2` set on `fpu_in1_ack`/`fpu_in2_ack`. Acks may arrive in the same cycle or in different cycles.
  - When both are set (counting the current cycle) → WAIT; strobes drop on the next cycle.
- WAIT:
  - `fpu_out_ack` = `fpu_out_stb` (combinational, WAIT only).
  - On `fpu_out_stb`, capture `fpu_out` into `rsp_data` → RESP.
- LOCAL: one cycle; compute the result → RESP.
  - 0110 feq, 0111 flt, 1000 fle: `rsp_data` = {31'b0, r}.
  - Any operand NaN (exp=FF, mant≠0) → r=0.
  - +0 and −0 compare equal.
  - Otherwise order by sign-magnitude.
  - 0100, 0101 (fcvt not supported in this revision) and 1001–1111: `rsp_data`=0, `rsp_illegal`=1.
- RESP:
  - `rsp_valid`=1; data, illegal and cycles held stable.
  - On `rsp_ready` → IDLE.
- Cycle counter: increments every cycle outside IDLE until RESP is entered; saturating.
- `fpu_op`, `fpu_in1`, `fpu_in2` are driven from the latched registers in every state, including IDLE (last op retained). This keeps the controller's output mux stable through `fpu_out_ack`.
- Reset values:
  - state IDLE.
  - `req_ready`=1 (combinational from IDLE).
  - `rsp_valid`=0, `rsp_data`=0, `rsp_illegal`=0, `rsp_cycles`=0.
  - `fpu_op`=0000, `fpu_in1`=`fpu_in2`=0.
  - Strobes 0, `fpu_out_ack`=0, got flags 0.
- Reset mid-transaction: immediate return to IDLE; the in-flight result is discarded. The controller units reset on the same `reset_n`.

## Timing
- Acceptance edge = end of cycle 0 (`req_valid`&&`req_ready`).
- Local ops: LOCAL in cycle 1, `rsp_valid` in cycle 2, `rsp_cycles`=2.
- FPU ops:
  - Strobes high from cycle 1.
  - If both acks arrive in cycle k, WAIT starts in cycle k+1.
  - If `fpu_out_stb` arrives in cycle m, `fpu_out_ack` is high in cycle m and `rsp_valid` in cycle m+1. `rsp_cycles`=m+1.
- No new request is accepted in the cycle the response is consumed. `req_ready` rises the cycle after the `rsp_ready` handshake.
- Requests presented outside IDLE are ignored (`req_ready`=0). The requester must hold them.
- `fpu_out_stb` outside WAIT is ignored; `fpu_out_ack` stays 0.

## Structure
- Shared package `fpu_pkg`:
  - 4-bit op enum matching the controller's encoding.
  - State enum `{IDLE, SEND, WAIT, LOCAL, RESP}`.
  - NaN/zero helper constants (EXP_MAX=8'hFF).
- One combinational sub-module `fpu_compare`: inputs a, b, op; outputs r.

## Test plan
- fadd 0x3F800000 + 0x40000000 → `rsp_data` 0x40400000, `rsp_illegal`=0. Strobes drop the cycle after both acks; `fpu_out_ack` high exactly one cycle.
- fsub 0x40400000 − 0x3F800000 → `rsp_data` 0x40000000. `fpu_op` stays 0001 from SEND through the `fpu_out_ack` cycle.
- flt 0xBF800000 < 0x3F800000 → `rsp_data` 1 and `rsp_cycles`=2. feq 0x80000000 vs 0x00000000 → 1. fle 0x7FC00000 vs 0x3F800000 → 0.
- fcvt.s.w (0100), any operands → `rsp_data` 0, `rsp_illegal`=1, `rsp_cycles`=2. Controller strobes never asserted.
- fdiv 0x40C00000 / 0x40000000 with `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_data` 0x40400000 stable throughout; `req_ready`=0 until the cycle after the handshake.
- `reset_n` asserted low while in WAIT during fmul → all outputs return to reset values asynchronously. After release, fmul 0x40000000 × 0x40400000 → `rsp_data` 0x40C00000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP issue sequencer and its local compare unit.
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_FADD     = 4'b0000,
    OP_FSUB     = 4'b0001,
    OP_FMUL     = 4'b0010,
    OP_FDIV     = 4'b0011,
    OP_FCVT_S_W = 4'b0100,
    OP_FCVT_W_S = 4'b0101,
    OP_FEQ      = 4'b0110,
    OP_FLT      = 4'b0111,
    OP_FLE      = 4'b1000
  } fpu_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    LOCAL = 3'd3,
    RESP  = 3'd4
  } fpu_state_e;

  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [22:0] MANT_ZERO = 23'h0;
  localparam logic [30:0] MAG_ZERO = 31'h0;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == EXP_MAX) && (f[22:0] != MANT_ZERO);
  endfunction

endpackage

// File: rtl/fpu_compare.sv
// Combinational feq/flt/fle on IEEE-754 singles; NaN forces false, signed zeros are equal.
module fpu_compare
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic        r
);

  logic any_nan;
  logic zero_both;
  logic eq;
  logic lt;

  always_comb begin
    any_nan   = is_nan(a) || is_nan(b);
    zero_both = (a[30:0] == MAG_ZERO) && (b[30:0] == MAG_ZERO);
    eq        = zero_both || (a == b);

    // Sign-magnitude ordering: for two negatives the larger magnitude is smaller.
    if (zero_both)
      lt = 1'b0;
    else if (a[31] != b[31])
      lt = a[31];
    else if (a[31])
      lt = a[30:0] > b[30:0];
    else
      lt = a[30:0] < b[30:0];

    r = 1'b0;
    if (op == OP_FEQ)
      r = eq;
    else if (op == OP_FLT)
      r = lt;
    else if (op == OP_FLE)
      r = lt || eq;

    if (any_nan)
      r = 1'b0;
  end

endmodule

// File: rtl/fpu_issue.sv
// Sequencer between the execute stage and fpu_controller: request latch, stb/ack
// operand handshake, result collection, local compares and a valid/ready response.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int CYCLE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [31:0]            req_a,
  input  logic [31:0]            req_b,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_illegal,
  output logic [CYCLE_CNT_W-1:0] rsp_cycles,

  output logic [3:0]             fpu_op,
  output logic [31:0]            fpu_in1,
  output logic [31:0]            fpu_in2,
  output logic                   fpu_in1_stb,
  output logic                   fpu_in2_stb,
  input  logic                   fpu_in1_ack,
  input  logic                   fpu_in2_ack,
  input  logic [31:0]            fpu_out,
  input  logic                   fpu_out_stb,
  output logic                   fpu_out_ack
);

  fpu_state_e             state;
  logic [3:0]             op_q;
  logic [31:0]            a_q;
  logic [31:0]            b_q;
  logic                   got1;
  logic                   got2;
  logic                   stb_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_data_q;
  logic                   rsp_illegal_q;
  logic [CYCLE_CNT_W-1:0] cyc_q;

  logic                   got1_n;
  logic                   got2_n;
  logic                   is_cmp;
  logic                   cmp_r;
  logic [CYCLE_CNT_W-1:0] cyc_inc;

  fpu_compare u_compare (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .r  (cmp_r)
  );

  always_comb begin
    got1_n  = got1 || fpu_in1_ack;
    got2_n  = got2 || fpu_in2_ack;
    is_cmp  = (op_q == OP_FEQ) || (op_q == OP_FLT) || (op_q == OP_FLE);
    cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CYCLE_CNT_W'(1);
  end

  // cyc_q holds the index of the current cycle counted from acceptance (cycle 0),
  // so its value after the final busy cycle is the cycle rsp_valid first shows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      op_q          <= 4'b0000;
      a_q           <= 32'h0;
      b_q           <= 32'h0;
      got1          <= 1'b0;
      got2          <= 1'b0;
      stb_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
      rsp_illegal_q <= 1'b0;
      cyc_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            got1  <= 1'b0;
            got2  <= 1'b0;
            cyc_q <= CYCLE_CNT_W'(1);
            if (req_op <= OP_FDIV) begin
              state <= SEND;
              stb_q <= 1'b1;
            end else begin
              state <= LOCAL;
            end
          end
        end
        SEND: begin
          cyc_q <= cyc_inc;
          if (got1_n && got2_n) begin
            state <= WAIT;
            stb_q <= 1'b0;
            got1  <= 1'b0;
            got2  <= 1'b0;
          end else begin
            got1 <= got1_n;
            got2 <= got2_n;
          end
        end
        WAIT: begin
          cyc_q <= cyc_inc;
          if (fpu_out_stb) begin
            rsp_data_q    <= fpu_out;
            rsp_illegal_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end
        end
        LOCAL: begin
          cyc_q       <= cyc_inc;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
          if (is_cmp) begin
            rsp_data_q    <= {31'b0, cmp_r};
            rsp_illegal_q <= 1'b0;
          end else begin
            rsp_data_q    <= 32'h0;
            rsp_illegal_q <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_cycles  = cyc_q;
  assign fpu_op      = op_q;
  assign fpu_in1     = a_q;
  assign fpu_in2     = b_q;
  assign fpu_in1_stb = stb_q;
  assign fpu_in2_stb = stb_q;
  // Result ack is only meaningful while waiting; stray strobes elsewhere are ignored.
  assign fpu_out_ack = (state == WAIT) && fpu_out_stb;

endmodule
